mem_port_arbiter: RTL and testbench

- Shares one single-port byte-addressed backing memory between the fetch stage (10-byte instruction reads) and the memory stage (64-bit data reads/writes).
- Sequences the two-beat instruction fetch and arbitrates with memory-stage priority plus a starvation guard for fetch.
- Range-checks every request and reports imem/dmem errors without touching memory.

---
 rtl/y86_mem_pkg.sv | 24 ++
 rtl/mem_arb_prio.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_mem_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
package y86_mem_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DM   = 3'd1,
        IF0  = 3'd2,
        IF1  = 3'd3,
        ERR  = 3'd4,
        RESP = 3'd5
    } arb_state_e;

    localparam int INST_BYTES        = 10;
    localparam int WORD_BYTES        = 8;
    localparam int MEM_BYTES_DEFAULT = 2048;

    // True when an access of access_bytes starting at addr would run past the end of memory.
    function automatic logic addr_out_of_range(input logic [63:0] addr,
                                               input int          mem_bytes,
                                               input int          access_bytes);
        return addr > $unsigned(64'(mem_bytes - access_bytes));
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch and data with a starvation guard for fetch.
module mem_arb_prio
    import y86_mem_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic if_req,
    input  logic dm_req,
    output logic grant_dm,
    output logic grant_if
);

    localparam int SW = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    logic [SW-1:0] streak;
    logic          fetch_due;

    // Data normally wins; once fetch has waited through enough data grants it takes the next slot.
    always_comb begin
        fetch_due = if_req && (streak == STREAK_MAX);
        grant_dm  = arb_en && dm_req && !fetch_due;
        grant_if  = arb_en && if_req && !grant_dm;
    end

    // Count consecutive data grants that were taken while fetch was left waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (grant_if) begin
            streak <= '0;
        end else if (grant_dm) begin
            streak <= if_req ? streak + SW'(1) : '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port byte memory between the fetch stage (two-beat
// 10-byte instruction reads) and the memory stage (64-bit reads/writes).
module mem_port_arbiter
    import y86_mem_pkg::*;
#(
    parameter int MEM_BYTES       = MEM_BYTES_DEFAULT,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_done,
    output logic [79:0] if_inst,
    output logic        if_err,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    output logic        dm_done,
    output logic [63:0] dm_rdata,
    output logic        dm_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [63:0] mem_rdata
);

    arb_state_e  state;
    logic        owner_if;
    logic [63:0] word0;
    logic        arb_en;
    logic        grant_dm;
    logic        grant_if;
    logic        if_bad;
    logic        dm_bad;

    // Arbitration only happens while no transaction is in flight.
    always_comb begin
        arb_en = (state == IDLE);
        if_bad = addr_out_of_range(if_addr, MEM_BYTES, INST_BYTES);
        dm_bad = addr_out_of_range(dm_addr, MEM_BYTES, WORD_BYTES);
    end

    mem_arb_prio #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .arb_en  (arb_en),
        .if_req  (if_req),
        .dm_req  (dm_req),
        .grant_dm(grant_dm),
        .grant_if(grant_if)
    );

    // Transaction sequencer; every port-facing output is a register driven from here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_if  <= 1'b0;
            word0     <= '0;
            if_done   <= 1'b0;
            if_inst   <= '0;
            if_err    <= 1'b0;
            dm_done   <= 1'b0;
            dm_rdata  <= '0;
            dm_err    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        owner_if <= 1'b0;
                        if (dm_bad) begin
                            state <= ERR;
                        end else begin
                            state     <= DM;
                            mem_req   <= 1'b1;
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                        end
                    end else if (grant_if) begin
                        owner_if <= 1'b1;
                        if (if_bad) begin
                            state <= ERR;
                        end else begin
                            state    <= IF0;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= if_addr;
                        end
                    end
                end
                DM: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                        dm_done <= 1'b1;
                        dm_err  <= 1'b0;
                        state   <= RESP;
                    end
                end
                IF0: begin
                    if (mem_ready) begin
                        word0    <= mem_rdata;
                        mem_addr <= mem_addr + 64'd2;
                        state    <= IF1;
                    end
                end
                IF1: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if_inst <= {mem_rdata[63:48], word0};
                        if_done <= 1'b1;
                        if_err  <= 1'b0;
                        state   <= RESP;
                    end
                end
                ERR: begin
                    if (owner_if) begin
                        if_done <= 1'b1;
                        if_err  <= 1'b1;
                    end else begin
                        dm_done <= 1'b1;
                        dm_err  <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if_done <= 1'b0;
                    if_err  <= 1'b0;
                    dm_done <= 1'b0;
                    dm_err  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural backing memory.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_done;
    logic [79:0] if_inst;
    logic        if_err;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        dm_done;
    logic [63:0] dm_rdata;
    logic        dm_err;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ready;
    logic [63:0] mem_rdata;

    int checks;
    int errors;

    logic [7:0]  mem_model [0:2047];
    int          wait_cycles;
    int          wait_cnt;
    int          req_cycles;
    logic [63:0] beat_q [$];

    int          obs_lat;
    logic        obs_done;
    logic        obs_err;
    int          obs_reqcyc;

    mem_port_arbiter #(
        .MEM_BYTES      (2048),
        .MAX_DATA_STREAK(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_inst  (if_inst),
        .if_err   (if_err),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_done  (dm_done),
        .dm_rdata (dm_rdata),
        .dm_err   (dm_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the DUT wedges somewhere no bounded wait covers.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [63:0] modelWord(input logic [63:0] a);
        logic [63:0] w;
        int base;
        w = '0;
        base = int'(a[11:0]);
        for (int k = 0; k < 8; k++) begin
            if (base + k < 2048) w[8*k +: 8] = mem_model[base + k];
        end
        return w;
    endfunction

    function automatic logic [79:0] modelInst(input logic [63:0] a);
        logic [63:0] w0;
        logic [63:0] w1;
        w0 = modelWord(a);
        w1 = modelWord(a + 64'd2);
        return {w1[63:48], w0};
    endfunction

    task automatic writeWord(input logic [63:0] a, input logic [63:0] d);
        int base;
        base = int'(a[11:0]);
        for (int k = 0; k < 8; k++) begin
            if (base + k < 2048) mem_model[base + k] = d[8*k +: 8];
        end
    endtask

    // Backing memory: answers each beat after wait_cycles idle cycles.
    initial begin
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        wait_cnt   = 0;
        req_cycles = 0;
        forever begin
            @(negedge clk);
            if (mem_req) req_cycles++;
            if (rst || !mem_req) begin
                mem_ready = 1'b0;
                wait_cnt  = 0;
            end else if (wait_cnt < wait_cycles) begin
                mem_ready = 1'b0;
                wait_cnt++;
            end else begin
                mem_ready = 1'b1;
                wait_cnt  = 0;
                mem_rdata = modelWord(mem_addr);
                beat_q.push_back(mem_addr);
                if (mem_we) writeWord(mem_addr, mem_wdata);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Runs one complete request on the chosen port and records latency, error flag and memory cycles.
    task automatic applyStimulus(input string tag, input bit is_if, input bit we,
                                 input logic [63:0] addr, input logic [63:0] wdata);
        int req_start;
        @(negedge clk);
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            dm_req   = 1'b1;
            dm_we    = we;
            dm_addr  = addr;
            dm_wdata = wdata;
        end
        req_start = req_cycles;
        beat_q.delete();
        obs_lat  = 0;
        obs_done = 1'b0;
        obs_err  = 1'b0;
        while (!obs_done && obs_lat < 50) begin
            @(posedge clk);
            #1;
            obs_lat++;
            if (is_if ? if_done : dm_done) begin
                obs_done = 1'b1;
                obs_err  = is_if ? if_err : dm_err;
            end
        end
        checkOutput({tag, "_done"}, 80'(obs_done), 80'd1);
        @(negedge clk);
        if_req = 1'b0;
        dm_req = 1'b0;
        obs_reqcyc = req_cycles - req_start;
    endtask

    initial begin
        int          n;
        int          cyc;
        int          pulses;
        logic [9:0]  order;
        logic [63:0] exp_rd;

        checks      = 0;
        errors      = 0;
        wait_cycles = 0;
        rst         = 1'b1;
        if_req      = 1'b0;
        if_addr     = '0;
        dm_req      = 1'b0;
        dm_we       = 1'b0;
        dm_addr     = '0;
        dm_wdata    = '0;

        for (int i = 0; i < 2048; i++) mem_model[i] = 8'(i * 13 + 7);
        writeWord(64'h10, 64'h1122334455667788);
        for (int i = 0; i < 10; i++) mem_model[32 + i] = 8'(i + 1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_mem_req", 80'(mem_req), 80'd0);
        checkOutput("rst_if_done", 80'(if_done), 80'd0);
        checkOutput("rst_dm_done", 80'(dm_done), 80'd0);
        checkOutput("rst_if_inst", if_inst, 80'd0);
        checkOutput("rst_dm_rdata", 80'(dm_rdata), 80'd0);
        checkOutput("rst_mem_addr", 80'(mem_addr), 80'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] data read, zero wait");
        applyStimulus("rd10", 1'b0, 1'b0, 64'h10, 64'h0);
        checkOutput("rd10_lat", 80'(obs_lat), 80'd2);
        checkOutput("rd10_rdata", 80'(dm_rdata), 80'h1122334455667788);
        checkOutput("rd10_err", 80'(obs_err), 80'd0);
        checkOutput("rd10_memcyc", 80'(obs_reqcyc), 80'd1);

        $display("[TB] fetch, zero wait");
        applyStimulus("if20", 1'b1, 1'b0, 64'h20, 64'h0);
        checkOutput("if20_lat", 80'(obs_lat), 80'd3);
        checkOutput("if20_inst", if_inst, 80'h0A090807060504030201);
        checkOutput("if20_err", 80'(obs_err), 80'd0);
        checkOutput("if20_beats", 80'(beat_q.size()), 80'd2);
        if (beat_q.size() == 2) begin
            checkOutput("if20_beat0", 80'(beat_q[0]), 80'h20);
            checkOutput("if20_beat1", 80'(beat_q[1]), 80'h22);
        end
        checkOutput("if20_memcyc", 80'(obs_reqcyc), 80'd2);

        $display("[TB] grant order under contention");
        @(negedge clk);
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 64'h40;
        if_req  = 1'b1;
        if_addr = 64'h60;
        n     = 0;
        cyc   = 0;
        order = '0;
        while (n < 10 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (dm_done) n++;
            if (if_done) begin
                order[n] = 1'b1;
                n++;
            end
        end
        @(negedge clk);
        dm_req = 1'b0;
        if_req = 1'b0;
        checkOutput("grant_count", 80'(n), 80'd10);
        checkOutput("grant_order", 80'(order), 80'h210);

        $display("[TB] range errors");
        applyStimulus("iferr", 1'b1, 1'b0, 64'd2039, 64'h0);
        checkOutput("iferr_lat", 80'(obs_lat), 80'd2);
        checkOutput("iferr_err", 80'(obs_err), 80'd1);
        checkOutput("iferr_memcyc", 80'(obs_reqcyc), 80'd0);
        checkOutput("iferr_inst_kept", if_inst, modelInst(64'h60));
        applyStimulus("dmerr", 1'b0, 1'b0, 64'd2041, 64'h0);
        checkOutput("dmerr_lat", 80'(obs_lat), 80'd2);
        checkOutput("dmerr_err", 80'(obs_err), 80'd1);
        checkOutput("dmerr_memcyc", 80'(obs_reqcyc), 80'd0);
        checkOutput("dmerr_rdata_kept", 80'(dm_rdata), 80'(modelWord(64'h40)));
        applyStimulus("ifedge", 1'b1, 1'b0, 64'd2038, 64'h0);
        checkOutput("ifedge_err", 80'(obs_err), 80'd0);
        checkOutput("ifedge_inst", if_inst, modelInst(64'd2038));

        $display("[TB] write then read back");
        exp_rd = modelWord(64'h40);
        applyStimulus("wr100", 1'b0, 1'b1, 64'h100, 64'hCAFEF00D12345678);
        checkOutput("wr100_err", 80'(obs_err), 80'd0);
        checkOutput("wr100_rdata_kept", 80'(dm_rdata), 80'(exp_rd));
        applyStimulus("rd100", 1'b0, 1'b0, 64'h100, 64'h0);
        checkOutput("rd100_rdata", 80'(dm_rdata), 80'hCAFEF00D12345678);

        $display("[TB] wait states");
        wait_cycles = 2;
        applyStimulus("rdw2", 1'b0, 1'b0, 64'h10, 64'h0);
        checkOutput("rdw2_lat", 80'(obs_lat), 80'd4);
        checkOutput("rdw2_memcyc", 80'(obs_reqcyc), 80'd3);
        checkOutput("rdw2_rdata", 80'(dm_rdata), 80'h1122334455667788);
        wait_cycles = 1;
        applyStimulus("ifw1", 1'b1, 1'b0, 64'h20, 64'h0);
        checkOutput("ifw1_lat", 80'(obs_lat), 80'd5);
        checkOutput("ifw1_inst", if_inst, 80'h0A090807060504030201);

        $display("[TB] reset during a stalled write");
        wait_cycles = 3;
        @(negedge clk);
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 64'h80;
        dm_wdata = 64'hDEADBEEF00000001;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstmid_mem_req", 80'(mem_req), 80'd0);
        checkOutput("rstmid_dm_done", 80'(dm_done), 80'd0);
        checkOutput("rstmid_mem_we", 80'(mem_we), 80'd0);
        checkOutput("rstmid_mem_addr", 80'(mem_addr), 80'd0);
        checkOutput("rstmid_mem_wdata", 80'(mem_wdata), 80'd0);
        checkOutput("rstmid_dm_rdata", 80'(dm_rdata), 80'd0);
        checkOutput("rstmid_if_inst", if_inst, 80'd0);
        @(negedge clk);
        rst    = 1'b0;
        dm_req = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (dm_done || mem_req) pulses++;
        end
        checkOutput("rstmid_quiet", 80'(pulses), 80'd0);
        wait_cycles = 0;
        applyStimulus("rdpost", 1'b0, 1'b0, 64'h10, 64'h0);
        checkOutput("rdpost_lat", 80'(obs_lat), 80'd2);
        checkOutput("rdpost_rdata", 80'(dm_rdata), 80'h1122334455667788);
        checkOutput("rdpost_err", 80'(obs_err), 80'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
